dvsd_mul_pipe: RTL
==================

DVSD_MUL_PIPE -- requirements
Module: dvsd_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal range 4..32.
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth in register stages; legal range 1..4.
REQ-003 SHALL have port clock  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1: operands a, b present this cycle.
REQ-006 SHALL have port in_ready  output  1: block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH: multiplicand.
REQ-008 SHALL have port b  input  WIDTH: multiplier.
REQ-009 SHALL have port out_valid  output  1: m holds a valid product.
REQ-010 SHALL have port out_ready  input  1: consumer accepts m this cycle.
REQ-011 SHALL have port m  output  2*WIDTH: product.
REQ-012 SHALL have port busy  output  1: high while any pipeline stage holds a valid entry.

Function
REQ-013 SHALL compute m = a * b at full width 2*WIDTH with no truncation or saturation; unsigned by default.
REQ-014 SHALL use a partial-product reduction tree split across STAGES register stages; each stage carries its own valid bit.
REQ-015 SHALL define advance = !out_valid || out_ready; all stages shift together when advance=1 and hold otherwise.
REQ-016 SHALL drive in_ready = advance; a transfer occurs on a cycle with in_valid && in_ready.
REQ-017 SHALL produce out_valid exactly STAGES cycles after the accepting edge when out_ready is held high (latency = STAGES).
REQ-018 SHALL sustain one accepted operand pair per cycle while out_ready=1 (full throughput, no bubbles inserted).
REQ-019 SHALL keep m and out_valid stable while out_valid=1 && out_ready=0; no product lost or duplicated.
REQ-020 SHALL, on a cycle with out_valid && out_ready && in_valid, accept the new operands and retire the oldest result together.
REQ-021 SHALL advance bubbles: a stage with its valid bit low never blocks upstream stages from filling it.
REQ-022 SHALL hold m at its last value while out_valid=0; the bench checks m only while out_valid=1.
REQ-023 SHALL deliver results in acceptance order.
REQ-024 SHALL produce m = 0 when either operand is 0, and m = (2^WIDTH-1)^2 for all-ones operands.

Reset
REQ-025 SHALL, with reset=1 at a clock edge, clear all stage valid bits, m to 0, out_valid to 0 and busy to 0.
REQ-026 SHALL drive in_ready=0 while reset=1; in_ready rises in the cycle after reset deasserts.
REQ-027 SHALL discard all in-flight operands when reset asserts mid-operation; no stale product appears afterwards.

Configuration
REQ-028 SHALL, with macro DVSD_MUL_SIGNED_EN defined, add port sgn  input  1, captured with a, b and pipelined alongside them; sgn=1 treats a, b as two's complement and m as a signed 2*WIDTH product; sgn=0 behaves as unsigned.
REQ-029 SHALL, without DVSD_MUL_SIGNED_EN, omit port sgn and perform unsigned multiplication only, with identical timing.

Verification
REQ-030 SHALL cover: defaults, a=0xFF, b=0xFF accepted, out_ready=1 -> out_valid two cycles later with m=0xFE01.
REQ-031 SHALL cover: four back-to-back random pairs, out_ready=1 -> four consecutive out_valid cycles, in order, each m equal to a*b.
REQ-032 SHALL cover: a result pending while out_ready=0 for 3 cycles -> m and out_valid stable and in_ready=0 once the pipe is full; the same sequence resumes when out_ready returns to 1.
REQ-033 SHALL cover: reset asserted one cycle after accepting a=0x12, b=0x34 -> out_valid never rises for that pair; busy=0 after reset.
REQ-034 SHALL cover: DVSD_MUL_SIGNED_EN defined, sgn=1: a=0xFF, b=0xFF -> m=0x0001; a=0x80, b=0x7F -> m=0xC080; sgn=0 with a=0x80, b=0x7F -> m=0x3F80.
REQ-035 SHALL cover: WIDTH=16, STAGES=4, a=0xFFFF, b=0xFFFF -> m=0xFFFE0001 four cycles after acceptance.

Source files
------------

// File: rtl/dvsd_mul_pipe.sv
// Pipelined WIDTH x WIDTH multiplier: partial-product rows are split across STAGES valid/ready stages.
// Optional DVSD_MUL_SIGNED_EN adds the sgn port to select a two's-complement product.
module dvsd_mul_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] m,
`ifdef DVSD_MUL_SIGNED_EN
    input  logic               sgn,
`endif
    output logic               busy
);

    localparam int PW  = 2 * WIDTH;
    localparam int RPS = (WIDTH + STAGES - 1) / STAGES;

    logic              w_advance;
    logic              w_take;
    logic              w_sgn;
    logic [PW-1:0]     w_aext;
    logic [STAGES-1:0] w_vin;
    logic [STAGES-1:0] w_sin;
    logic [PW-1:0]     w_accin [STAGES];
    logic [PW-1:0]     w_ain   [STAGES];
    logic [WIDTH-1:0]  w_bin   [STAGES];
    logic [STAGES-1:0] w_vq;
    logic [PW-1:0]     w_accq  [STAGES];

`ifdef DVSD_MUL_SIGNED_EN
    assign w_sgn = sgn;
`else
    assign w_sgn = 1'b0;
`endif

    // Signed mode: sign-extend a and give the top b row negative weight.
    function automatic logic [PW-1:0] rows_sum(
        input logic [PW-1:0]    a_ext,
        input logic [WIDTH-1:0] b_op,
        input logic             s_op,
        input int               lo,
        input int               hi
    );
        logic [PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= lo && i < hi && b_op[i]) begin
                if (s_op && i == WIDTH - 1)
                    acc = acc - (a_ext << i);
                else
                    acc = acc + (a_ext << i);
            end
        end
        return acc;
    endfunction

    assign w_aext    = w_sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = !reset && w_advance;
    assign w_take    = in_valid && in_ready;

    assign w_vin[0]   = w_take;
    assign w_accin[0] = '0;
    assign w_ain[0]   = w_aext;
    assign w_bin[0]   = b;
    assign w_sin[0]   = w_sgn;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic          r_vld;
        logic [PW-1:0] r_acc;

        // Payload loads only with a valid entry so m holds its last product across bubbles.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_vld <= 1'b0;
                r_acc <= '0;
            end else if (w_advance) begin
                r_vld <= w_vin[s];
                if (w_vin[s])
                    r_acc <= w_accin[s] + rows_sum(w_ain[s], w_bin[s], w_sin[s], s * RPS, (s + 1) * RPS);
            end
        end

        assign w_vq[s]   = r_vld;
        assign w_accq[s] = r_acc;

        if (s < STAGES - 1) begin : g_fwd
            logic [PW-1:0]    r_a;
            logic [WIDTH-1:0] r_b;
            logic             r_sgn;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_sgn <= 1'b0;
                end else if (w_advance && w_vin[s]) begin
                    r_a   <= w_ain[s];
                    r_b   <= w_bin[s];
                    r_sgn <= w_sin[s];
                end
            end

            assign w_vin[s+1]   = r_vld;
            assign w_accin[s+1] = r_acc;
            assign w_ain[s+1]   = r_a;
            assign w_bin[s+1]   = r_b;
            assign w_sin[s+1]   = r_sgn;
        end
    end

    assign out_valid = w_vq[STAGES-1];
    assign m         = w_accq[STAGES-1];
    assign busy      = |w_vq;

endmodule
